// File: rtl/sysctl_term.sv
// sysctl_term: 68030 asynchronous bus-cycle terminator.
// Turns decoder chip selects into DSACK with per-channel wait states and port
// width, and raises BERR on timeout or on a multiple-select decode fault,
// capturing the fault details for software.
module sysctl_term #(
  parameter int                   NCHAN   = 4,
  parameter int                   WSW     = 4,
  parameter logic [NCHAN*WSW-1:0] WAITS   = '0,
  parameter logic [NCHAN*2-1:0]   PORTSZ  = '0,
  parameter int                   TIMEOUT = 64,
  localparam int                  CW      = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
  input  logic             CPU_CLK,
  input  logic             nRST,
  input  logic             nAS,
  input  logic [NCHAN-1:0] nSEL,
  input  logic [NCHAN-1:0] EXTWAIT,
  output logic [1:0]       DSACK,
  output logic             BERR,
  output logic [CW-1:0]    FAULT_CH,
  output logic             FAULT_NOSEL,
  output logic             FAULT_MULTI,
  output logic [7:0]       BERR_CNT
);

  localparam int             TW   = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]  TLIM = TW'(TIMEOUT);

  // Largest programmed wait count, used only for the elaboration check.
  function automatic int max_waits();
    int m = 0;
    for (int i = 0; i < NCHAN; i++) begin
      if (int'(WAITS[i*WSW +: WSW]) > m) m = int'(WAITS[i*WSW +: WSW]);
    end
    return m;
  endfunction

  if (NCHAN < 1 || NCHAN > 16) begin : g_bad_nchan
    $error("sysctl_term: NCHAN must be in 1..16");
  end
  if (TIMEOUT <= max_waits() + 1) begin : g_bad_timeout
    $error("sysctl_term: TIMEOUT must exceed max(WAITS)+1");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_ERR} state_t;

  state_t         state_q, state_d;
  logic [WSW-1:0] wcnt_q;
  logic [TW-1:0]  tcnt_q;
  logic [CW-1:0]  ch_q;
  logic           ch_valid_q;

  logic [1:0]     sel_cnt;
  logic [CW-1:0]  sel_low;
  logic           sel_found;
  logic [WSW-1:0] waits_sel;
  logic [WSW-1:0] wcnt_dec;
  logic [TW-1:0]  tcnt_inc;
  logic           timeout_hit;
  logic           multi_hit;

  // Decode the chip selects: how many are active (saturating at 2) and the lowest one.
  // NOTE: every combinational output gets a default before any branch, so no latch is inferred;
  // blocking assignments are correct here because the loop accumulates within one evaluation.
  always_comb begin
    sel_cnt   = 2'd0;
    sel_low   = '0;
    sel_found = 1'b0;
    for (int i = 0; i < NCHAN; i++) begin
      if (!nSEL[i]) begin
        if (!sel_found) begin
          sel_low   = CW'(i);
          sel_found = 1'b1;
        end
        if (sel_cnt != 2'd2) sel_cnt = sel_cnt + 2'd1;
      end
    end
  end

  assign waits_sel = WAITS[int'(sel_low)*WSW +: WSW];
  assign wcnt_dec  = (wcnt_q != '0) ? wcnt_q - WSW'(1) : '0;
  assign tcnt_inc  = tcnt_q + TW'(1);

  // Next-state logic; ACK beats a coincident timeout, nAS high always returns to IDLE.
  always_comb begin
    state_d     = state_q;
    timeout_hit = 1'b0;
    multi_hit   = 1'b0;
    if (nAS) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (sel_cnt == 2'd0) begin
            state_d = S_WAIT;
          end else if (sel_cnt == 2'd1) begin
            state_d = (waits_sel == '0 && !EXTWAIT[sel_low]) ? S_ACK : S_WAIT;
          end else begin
            state_d   = S_ERR;
            multi_hit = 1'b1;
          end
        end
        S_WAIT: begin
          if (ch_valid_q && wcnt_dec == '0 && !EXTWAIT[ch_q]) begin
            state_d = S_ACK;
          end else if (tcnt_inc == TLIM) begin
            state_d     = S_ERR;
            timeout_hit = 1'b1;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // State, counters, latched channel and fault capture registers.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CPU_CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= S_IDLE;
      wcnt_q      <= '0;
      tcnt_q      <= '0;
      ch_q        <= '0;
      ch_valid_q  <= 1'b0;
      FAULT_CH    <= '0;
      FAULT_NOSEL <= 1'b0;
      FAULT_MULTI <= 1'b0;
      BERR_CNT    <= 8'd0;
    end else begin
      state_q <= state_d;
      if (nAS) begin
        wcnt_q <= '0;
        tcnt_q <= '0;
      end else begin
        if (state_q == S_IDLE || state_q == S_WAIT) tcnt_q <= tcnt_inc;
        if (state_q == S_IDLE) begin
          wcnt_q     <= waits_sel;
          ch_q       <= sel_low;
          ch_valid_q <= (sel_cnt == 2'd1);
        end else if (state_q == S_WAIT) begin
          wcnt_q <= wcnt_dec;
        end
      end
      if (multi_hit) begin
        FAULT_CH    <= sel_low;
        FAULT_NOSEL <= 1'b0;
        FAULT_MULTI <= 1'b1;
      end else if (timeout_hit) begin
        FAULT_CH    <= ch_q;
        FAULT_NOSEL <= !ch_valid_q;
        FAULT_MULTI <= 1'b0;
      end
      if ((multi_hit || timeout_hit) && BERR_CNT != 8'hFF) BERR_CNT <= BERR_CNT + 8'd1;
    end
  end

  // Termination outputs from registered state, gated by nAS so they drop as soon as nAS rises.
  always_comb begin
    DSACK = 2'b00;
    BERR  = 1'b0;
    if (!nAS) begin
      if (state_q == S_ACK) begin
        unique case (PORTSZ[int'(ch_q)*2 +: 2])
          2'b01:   DSACK = 2'b01;
          2'b10:   DSACK = 2'b10;
          default: DSACK = 2'b11;
        endcase
      end
      BERR = (state_q == S_ERR);
    end
  end

endmodule

// File: tb/tb_sysctl_term.sv
// tb_sysctl_term: randomized self-checking bench for sysctl_term against a
// cycle-outcome reference model (termination edge and kind per bus cycle).
module tb_sysctl_term;

  localparam int          NCHAN   = 4;
  localparam int          WSW     = 4;
  localparam int          TIMEOUT = 64;
  localparam logic [15:0] WAITS   = {4'd5, 4'd3, 4'd0, 4'd0};
  localparam logic [7:0]  PORTSZ  = {2'b11, 2'b01, 2'b10, 2'b00};

  // Reference tables, channel 0 first: wait states and DSACK for each port width.
  int         waits_tab [NCHAN] = '{0, 0, 3, 5};
  logic [1:0] ack_tab   [NCHAN] = '{2'b11, 2'b10, 2'b01, 2'b11};

  logic       CPU_CLK = 1'b0;
  logic       nRST;
  logic       nAS;
  logic [3:0] nSEL;
  logic [3:0] EXTWAIT;
  logic [1:0] DSACK;
  logic       BERR;
  logic [1:0] FAULT_CH;
  logic       FAULT_NOSEL;
  logic       FAULT_MULTI;
  logic [7:0] BERR_CNT;

  sysctl_term #(
    .NCHAN(NCHAN), .WSW(WSW), .WAITS(WAITS), .PORTSZ(PORTSZ), .TIMEOUT(TIMEOUT)
  ) dut (
    .CPU_CLK(CPU_CLK), .nRST(nRST), .nAS(nAS), .nSEL(nSEL), .EXTWAIT(EXTWAIT),
    .DSACK(DSACK), .BERR(BERR), .FAULT_CH(FAULT_CH), .FAULT_NOSEL(FAULT_NOSEL),
    .FAULT_MULTI(FAULT_MULTI), .BERR_CNT(BERR_CNT)
  );

  always #5 CPU_CLK = ~CPU_CLK;

  int n_vec = 0;
  int n_bad = 0;

  // Model of the fault capture registers.
  int m_fault_ch = 0;
  bit m_nosel    = 0;
  bit m_multi    = 0;
  int m_cnt      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_faults();
    if (!m_nosel) check("fault_ch", FAULT_CH, m_fault_ch);
    check("fault_nosel", FAULT_NOSEL, m_nosel);
    check("fault_multi", FAULT_MULTI, m_multi);
    check("berr_cnt", BERR_CNT, m_cnt);
  endtask

  // One bus cycle: nSEL pattern at the first edge, EXTWAIT of the selected channel
  // high for edges [ext_from, ext_from+ext_len), hold edges after termination,
  // optional reset pulse after edge rst_at (-1 = none).
  task automatic run_cycle(input logic [3:0] sel, input int ext_from, input int ext_len,
                           input int hold, input int rst_at);
    int   ones, ch, kind, term;   // kind: 0 = DSACK, 1 = timeout BERR, 2 = multi-select BERR
    logic [3:0] ext;
    ones = 0; ch = 0;
    for (int i = NCHAN - 1; i >= 0; i--) if (!sel[i]) begin ones++; ch = i; end
    if (ones >= 2) begin
      kind = 2; term = 0;
    end else begin
      kind = 1; term = TIMEOUT - 1;
      if (ones == 1) begin
        for (int j = 0; j < TIMEOUT; j++) begin
          if (j >= waits_tab[ch] && !(j >= ext_from && j < ext_from + ext_len)) begin
            kind = 0; term = j; break;
          end
        end
      end
    end

    for (int j = 0; j <= term + hold; j++) begin
      @(negedge CPU_CLK);
      nAS  = 1'b0;
      nSEL = (j == 0) ? sel : 4'($urandom);
      ext  = 4'($urandom);
      if (ones == 1) ext[ch] = (j >= ext_from && j < ext_from + ext_len);
      EXTWAIT = ext;
      @(posedge CPU_CLK);
      #1;
      if (j == term && kind != 0) begin
        m_fault_ch = ch;
        m_nosel    = (ones == 0);
        m_multi    = (kind == 2);
        m_cnt      = (m_cnt < 255) ? m_cnt + 1 : 255;
      end
      check("dsack", DSACK, (kind == 0 && j >= term) ? ack_tab[ch] : 2'b00);
      check("berr", BERR, (kind != 0 && j >= term));
      check_faults();
      if (j == rst_at) begin
        #2 nRST = 1'b0;
        #1;
        m_fault_ch = 0; m_nosel = 0; m_multi = 0; m_cnt = 0;
        check("rst_dsack", DSACK, 2'b00);
        check("rst_berr", BERR, 1'b0);
        check("rst_fault_ch", FAULT_CH, 2'd0);
        check_faults();
        nAS = 1'b1;
        @(negedge CPU_CLK);
        nRST = 1'b1;
        return;
      end
    end

    @(negedge CPU_CLK);
    nAS = 1'b1;
    #1;
    check("negate_dsack", DSACK, 2'b00);
    check("negate_berr", BERR, 1'b0);
    @(posedge CPU_CLK);
    #1;
    check("idle_dsack", DSACK, 2'b00);
    check("idle_berr", BERR, 1'b0);
  endtask

  initial begin
    nRST = 1'b0; nAS = 1'b1; nSEL = 4'hF; EXTWAIT = 4'h0;
    #1;
    check("reset_dsack", DSACK, 2'b00);
    check("reset_berr", BERR, 1'b0);
    check("reset_fault_ch", FAULT_CH, 2'd0);
    check_faults();
    @(negedge CPU_CLK);
    @(negedge CPU_CLK);
    nRST = 1'b1;

    // Directed cases.
    run_cycle(4'b1110, 0, 0, 2, -1);    // ch0, no waits, 32-bit
    run_cycle(4'b1011, 0, 0, 2, -1);    // ch2, 3 waits, 8-bit
    run_cycle(4'b1011, 3, 2, 2, -1);    // ch2 extended two edges
    run_cycle(4'b0111, 0, 0, 1, -1);    // ch3, 5 waits, reserved width
    run_cycle(4'b1111, 0, 0, 2, -1);    // no select: timeout
    run_cycle(4'b1100, 0, 0, 2, -1);    // multi-select
    run_cycle(4'b1101, 0, 100, 2, -1);  // ch1 held by EXTWAIT: timeout
    run_cycle(4'b1101, 0, TIMEOUT - 1, 2, -1);  // ACK on the timeout edge
    run_cycle(4'b1110, 1, 3, 1, -1);    // EXTWAIT before edge k ignored on a zero-wait channel? no: at edge 0 low
    run_cycle(4'b1011, 0, 0, 0, 1);     // reset mid-WAIT
    run_cycle(4'b0011, 0, 0, 0, -1);    // multi-select to load fault state
    run_cycle(4'b1111, 0, 0, 3, TIMEOUT + 1);  // reset mid-ERR

    // Randomized cycles.
    for (int n = 0; n < 60; n++) begin
      logic [3:0] s;
      int r, a, b, ef, el;
      r = $urandom_range(0, 9);
      if (r <= 6) begin
        s = 4'hF; s[$urandom_range(0, 3)] = 1'b0;
      end else if (r == 7) begin
        s = 4'hF;
      end else begin
        a = $urandom_range(0, 3);
        b = (a + $urandom_range(1, 3)) % 4;
        s = 4'($urandom); s[a] = 1'b0; s[b] = 1'b0;
      end
      ef = $urandom_range(0, 7);
      el = ($urandom_range(0, 7) == 0) ? 80 : $urandom_range(0, 4);
      run_cycle(s, ef, el, $urandom_range(0, 2), -1);
    end

    // Enough timeouts to saturate the bus-error counter.
    for (int n = 0; n < 300; n++) run_cycle(4'b1111, 0, 0, 0, -1);
    check("berr_cnt_sat", BERR_CNT, 8'd255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
